// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the keypad entry block: FSM encodings,
// command key codes, reset column drive and column/row decode functions.
package keypad_pkg;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam logic [3:0] CODE_SEL_A  = 4'd10;
    localparam logic [3:0] CODE_SEL_B  = 4'd11;
    localparam logic [3:0] CODE_CLEAR  = 4'd12;
    localparam logic [3:0] CODE_DIGIT_MAX = 4'd9;

    localparam logic [3:0] COL_RESET   = 4'b1110;

    // Column drive is active-low; the next column is a left rotate.
    function automatic logic [3:0] rotate_col(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] col);
        logic [1:0] idx;
        idx = 2'd3;
        if (!col[0])      idx = 2'd0;
        else if (!col[1]) idx = 2'd1;
        else if (!col[2]) idx = 2'd2;
        return idx;
    endfunction

    // Lowest-index low row wins when several rows are pressed together.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] row);
        logic [1:0] idx;
        idx = 2'd3;
        if (!row[0])      idx = 2'd0;
        else if (!row[1]) idx = 2'd1;
        else if (!row[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Consecutive-sample counter: done fires on the DEBOUNCE_CNT-th good sample
// in a row; a bad sample or clear restarts the count.
module keypad_debounce #(
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic sample_en,
    input  logic sample_ok,
    output logic done
);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (sample_en) begin
            count <= sample_ok ? count + CW'(1) : '0;
        end
    end

    assign done = sample_en && sample_ok && (count == CW'(DEBOUNCE_CNT - 1));

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce and a two-operand BCD entry register.
// Optional macro KEYPAD_AUTO_ADVANCE_EN toggles the edited operand after each digit.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] op_a,
    output logic [3:0] op_b,
    output logic       sel_b
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    if (SCAN_DIV < 4) begin : g_bad_scan_div
        $error("SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE_CNT < 2) begin : g_bad_debounce_cnt
        $error("DEBOUNCE_CNT must be at least 2");
    end

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [SW-1:0] scan_cnt;
    logic          tick;
    logic [1:0]    state;
    logic [1:0]    row_idx;
    logic [1:0]    col_idx;
    logic [3:0]    press_code;
    logic          db_clear;
    logic          db_en;
    logic          db_ok;
    logic          db_done;

    // Idle rows are pulled high, so the synchronizer resets to "no key".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= key_row;
            row_sync <= row_meta;
        end
    end

    assign tick = (scan_cnt == SW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)    scan_cnt <= '0;
        else if (tick) scan_cnt <= '0;
        else           scan_cnt <= scan_cnt + SW'(1);
    end

    always_comb begin
        db_clear = 1'b1;
        db_en    = 1'b0;
        db_ok    = 1'b0;
        case (state)
            ST_DEBOUNCE: begin
                db_clear = 1'b0;
                db_en    = 1'b1;
                db_ok    = ~row_sync[row_idx];
            end
            ST_RELEASE: begin
                db_clear = 1'b0;
                db_en    = 1'b1;
                db_ok    = &row_sync;
            end
            default: ;
        endcase
    end

    keypad_debounce #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (db_clear),
        .sample_en(db_en),
        .sample_ok(db_ok),
        .done     (db_done)
    );

    assign press_code = {row_idx, col_idx};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_SCAN;
            key_col   <= COL_RESET;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            op_a      <= 4'd0;
            op_b      <= 4'd0;
            sel_b     <= 1'b0;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (tick) begin
                        if (row_sync != 4'hF) begin
                            col_idx <= col_index(key_col);
                            row_idx <= lowest_low_row(row_sync);
                            state   <= ST_DEBOUNCE;
                        end else begin
                            key_col <= rotate_col(key_col);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (!db_ok) begin
                        state <= ST_SCAN;
                    end else if (db_done) begin
                        key_valid <= 1'b1;
                        key_code  <= press_code;
                        state     <= ST_HELD;
                        // Only digits reach the operands, so they stay BCD.
                        if (press_code <= CODE_DIGIT_MAX) begin
                            if (sel_b) op_b <= press_code;
                            else       op_a <= press_code;
`ifdef KEYPAD_AUTO_ADVANCE_EN
                            sel_b <= ~sel_b;
`else
                            sel_b <= sel_b;
`endif
                        end else if (press_code == CODE_SEL_A) begin
                            sel_b <= 1'b0;
                        end else if (press_code == CODE_SEL_B) begin
                            sel_b <= 1'b1;
                        end else if (press_code == CODE_CLEAR) begin
                            op_a  <= 4'd0;
                            op_b  <= 4'd0;
                            sel_b <= 1'b0;
                        end
                    end
                end
                ST_HELD: begin
                    if (&row_sync) state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (db_done) begin
                        state   <= ST_SCAN;
                        key_col <= rotate_col(key_col);
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: keypad matrix model, table of key presses with
// expected operand state, and hand sequences for bounce, multi-key and reset.
module tb_keypad_entry;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;
`ifdef KEYPAD_AUTO_ADVANCE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [3:0]  op_a;
    logic [3:0]  op_b;
    logic        sel_b;
    logic [15:0] pressed;

    int checks    = 0;
    int errors    = 0;
    int valid_cnt = 0;
    logic [12:0] exp_q[$];

    typedef struct {
        logic [3:0] code;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic       exp_s;
    } vec_t;
    vec_t vecs[12];

    always #5 clk = ~clk;

    keypad_entry #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_valid(key_valid),
        .key_code (key_code),
        .op_a     (op_a),
        .op_b     (op_b),
        .sel_b    (sel_b)
    );

    // Keypad matrix: a pressed key shorts its row to its column when driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            key_row[r] = ~|(pressed[r*4 +: 4] & ~key_col);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: each key_valid pulse pops {code, op_a, op_b, sel_b}.
    always @(negedge clk) begin
        logic [12:0] e;
        if (key_valid === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual code=%0h required no pulse", key_code);
            end else begin
                e = exp_q.pop_front();
                check("valid_outputs", {19'd0, key_code, op_a, op_b, sel_b}, {19'd0, e});
            end
        end
        if (rst_n === 1'b1) check("col_one_low", $countones(~key_col), 1);
    end

    task automatic press_and_release(input logic [3:0] code, input int hold,
                                     input logic [3:0] ea, input logic [3:0] eb,
                                     input logic es);
        int v0;
        v0 = valid_cnt;
        exp_q.push_back({code, ea, eb, es});
        pressed[code] = 1'b1;
        repeat (hold) @(negedge clk);
        pressed = '0;
        repeat (20) @(negedge clk);
        check("valid_count", valid_cnt - v0, 1);
        check("op_a", op_a, ea);
        check("op_b", op_b, eb);
        check("sel_b", sel_b, es);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0;
        int budget;
        logic [3:0] seen;

        vecs[0]  = '{4'd6,  4'd6, 4'd0, AUTO ? 1'b1 : 1'b0};
        vecs[1]  = '{4'd11, 4'd6, 4'd0, 1'b1};
        vecs[2]  = '{4'd3,  4'd6, 4'd3, AUTO ? 1'b0 : 1'b1};
        vecs[3]  = '{4'd10, 4'd6, 4'd3, 1'b0};
        vecs[4]  = '{4'd7,  4'd7, 4'd3, AUTO ? 1'b1 : 1'b0};
        vecs[5]  = '{4'd11, 4'd7, 4'd3, 1'b1};
        vecs[6]  = '{4'd2,  4'd7, 4'd2, AUTO ? 1'b0 : 1'b1};
        vecs[7]  = '{4'd13, 4'd7, 4'd2, AUTO ? 1'b0 : 1'b1};
        vecs[8]  = '{4'd12, 4'd0, 4'd0, 1'b0};
        vecs[9]  = '{4'd15, 4'd0, 4'd0, 1'b0};
        vecs[10] = '{4'd9,  4'd9, 4'd0, AUTO ? 1'b1 : 1'b0};
        vecs[11] = '{4'd0,  AUTO ? 4'd9 : 4'd0, 4'd0, 1'b0};

        // Clock/reset
        pressed = '0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_key_col", key_col, 4'b1110);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_code", key_code, 0);
        check("rst_op_a", op_a, 0);
        check("rst_op_b", op_b, 0);
        check("rst_sel_b", sel_b, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            press_and_release(vecs[i].code, 40, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_s);
        end

        // Bounce: key 0 low for 5 cycles right after column 0 is selected.
        budget = 0;
        while (key_col == 4'b1110 && budget < 40) begin @(negedge clk); budget++; end
        while (key_col != 4'b1110 && budget < 40) begin @(negedge clk); budget++; end
        check("bounce_col0_wait", (budget < 40) ? 1 : 0, 1);
        v0 = valid_cnt;
        pressed[0] = 1'b1;
        repeat (5) @(negedge clk);
        pressed = '0;
        seen = '0;
        repeat (24) begin
            @(negedge clk);
            seen = seen | ~key_col;
        end
        check("bounce_no_valid", valid_cnt - v0, 0);
        check("bounce_rotation", seen, 4'hF);
        check("bounce_op_a", op_a, AUTO ? 4'd9 : 4'd0);

        // Rows 1 and 3 of column 0 together: code 4 wins over 12.
        v0 = valid_cnt;
        exp_q.push_back({4'd4, 4'd4, 4'd0, AUTO});
        pressed[4]  = 1'b1;
        pressed[12] = 1'b1;
        repeat (40) @(negedge clk);
        pressed = '0;
        repeat (20) @(negedge clk);
        check("multi_valid_count", valid_cnt - v0, 1);
        check("multi_op_a", op_a, 4'd4);

        // Reset while key 5 is held.
        v0 = valid_cnt;
        exp_q.push_back(AUTO ? {4'd5, 4'd4, 4'd5, 1'b0} : {4'd5, 4'd5, 4'd0, 1'b0});
        pressed[5] = 1'b1;
        budget = 0;
        while (valid_cnt == v0 && budget < 80) begin @(negedge clk); budget++; end
        check("held_first_valid", (budget < 80) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("hrst_key_col", key_col, 4'b1110);
        check("hrst_key_valid", key_valid, 0);
        check("hrst_key_code", key_code, 0);
        check("hrst_op_a", op_a, 0);
        check("hrst_op_b", op_b, 0);
        check("hrst_sel_b", sel_b, 0);
        exp_q.push_back({4'd5, 4'd5, 4'd0, AUTO});
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        pressed = '0;
        repeat (20) @(negedge clk);
        check("hrst_valid_count", valid_cnt - v0, 2);
        check("hrst_op_a_after", op_a, 4'd5);
        check("hrst_sel_b_after", sel_b, AUTO);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
